md_unit: RTL

- Parametrised multiply/divide unit with HI/LO registers for the pipelined MIPS core.
- Sits beside the EX-stage ALU. It accepts mult/multu/div/divu/mthi/mtlo from EX and holds results in HI/LO for mfhi/mflo.
- Models configurable multi-cycle latency and exposes a busy flag. The hazard unit uses busy to stall any md-class instruction in ID while an operation is in flight.
- Adds flush-cancel support for later exception work.

---
 rtl/md_pkg.sv | 32 +++
 rtl/md_arith.sv | 79 +++++++
 rtl/md_unit.sv | 137 +++++++++++++
 3 files changed

// File: rtl/md_pkg.sv
// Shared definitions for the multiply/divide unit. The decoder and the
// hazard unit use the same md_op encodings.
package md_pkg;

    // md_op encodings carried from decode through EX into the md unit.
    typedef enum logic [2:0] {
        MD_NOP   = 3'd0,
        MD_MULT  = 3'd1,
        MD_MULTU = 3'd2,
        MD_DIV   = 3'd3,
        MD_DIVU  = 3'd4,
        MD_MTHI  = 3'd5,
        MD_MTLO  = 3'd6,
        MD_RSVD  = 3'd7
    } md_op_e;

    // Control FSM: IDLE means busy=0, RUN means an operation is pending.
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } md_state_e;

    // Default latencies, in cycles of busy, for the multiply and divide classes.
    localparam int MD_MULT_LAT_DEF = 5;
    localparam int MD_DIV_LAT_DEF  = 10;

    // Larger of two latencies; sizes the shared down-counter.
    function automatic int md_max(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/md_arith.sv
// Combinational datapath for the md unit: produces the HI/LO pair an
// operation will eventually retire, plus a divide-by-zero flag. Kept apart
// from the control FSM so an iterative divider can replace it later.
module md_arith
    import md_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [2:0]       i_md_op,
    input  logic [WIDTH-1:0] i_src_a,
    input  logic [WIDTH-1:0] i_src_b,
    output logic [WIDTH-1:0] o_pending_hi,
    output logic [WIDTH-1:0] o_pending_lo,
    output logic             o_div_by_zero
);

    localparam int W2 = 2 * WIDTH;

    logic [W2-1:0]    w_prod_s;
    logic [W2-1:0]    w_prod_u;
    logic             w_b_zero;
    logic             w_ovf;
    logic [WIDTH-1:0] w_udiv_b;
    logic [WIDTH-1:0] w_sdiv_b;
    logic [WIDTH-1:0] w_q_u;
    logic [WIDTH-1:0] w_r_u;
    logic [WIDTH-1:0] w_q_s;
    logic [WIDTH-1:0] w_r_s;

    // A product of sign-extended operands, taken modulo 2^(2*WIDTH), is the
    // exact two's-complement signed product.
    assign w_prod_s = {{WIDTH{i_src_a[WIDTH-1]}}, i_src_a} * {{WIDTH{i_src_b[WIDTH-1]}}, i_src_b};
    assign w_prod_u = {{WIDTH{1'b0}}, i_src_a} * {{WIDTH{1'b0}}, i_src_b};

    assign w_b_zero = (i_src_b == '0);
    assign w_ovf    = (i_src_a == {1'b1, {(WIDTH-1){1'b0}}}) && (i_src_b == '1);

    // Divisors are steered to 1 in the degenerate cases so the dividers never
    // see /0 or the overflowing MIN/-1. MIN/1 yields exactly the required
    // overflow result (lo = most-negative, hi = 0); the /0 result is discarded.
    assign w_udiv_b = w_b_zero ? WIDTH'(1) : i_src_b;
    assign w_sdiv_b = (w_b_zero || w_ovf) ? WIDTH'(1) : i_src_b;

    assign w_q_u = i_src_a / w_udiv_b;
    assign w_r_u = i_src_a % w_udiv_b;
    // Signed / and % truncate toward zero; the remainder follows the dividend.
    assign w_q_s = $signed(i_src_a) / $signed(w_sdiv_b);
    assign w_r_s = $signed(i_src_a) % $signed(w_sdiv_b);

    // Select the HI/LO pair for the requested operation.
    always_comb begin
        // NOTE: every output gets a default first so no path can infer a latch.
        o_pending_hi  = '0;
        o_pending_lo  = '0;
        o_div_by_zero = 1'b0;
        case (md_op_e'(i_md_op))
            MD_MULT: begin
                o_pending_hi = w_prod_s[W2-1:WIDTH];
                o_pending_lo = w_prod_s[WIDTH-1:0];
            end
            MD_MULTU: begin
                o_pending_hi = w_prod_u[W2-1:WIDTH];
                o_pending_lo = w_prod_u[WIDTH-1:0];
            end
            MD_DIV: begin
                o_pending_hi  = w_r_s;
                o_pending_lo  = w_q_s;
                o_div_by_zero = w_b_zero;
            end
            MD_DIVU: begin
                o_pending_hi  = w_r_u;
                o_pending_lo  = w_q_u;
                o_div_by_zero = w_b_zero;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/md_unit.sv
// Multiply/divide unit with HI/LO registers. mult/div results are captured
// at issue and retired into HI/LO after a configurable latency, during which
// busy is high; mthi/mtlo write immediately. flush cancels a pending result.
module md_unit
    import md_pkg::*;
#(
    parameter int WIDTH    = 32,
    parameter int MULT_LAT = MD_MULT_LAT_DEF,
    parameter int DIV_LAT  = MD_DIV_LAT_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       md_op,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    input  logic             flush,
    output logic             busy,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CNT_W = $clog2(md_max(MULT_LAT, DIV_LAT)) + 1;

    md_state_e        r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;
    logic [WIDTH-1:0] r_pend_hi;
    logic [WIDTH-1:0] r_pend_lo;
    logic             r_pend_dz;

    md_state_e        w_state_nx;
    logic [CNT_W-1:0] w_cnt_nx;
    logic [WIDTH-1:0] w_hi_nx;
    logic [WIDTH-1:0] w_lo_nx;
    logic             w_capture;
    logic [WIDTH-1:0] w_arith_hi;
    logic [WIDTH-1:0] w_arith_lo;
    logic             w_arith_dz;
    md_op_e           w_op;

    assign w_op = md_op_e'(md_op);

    md_arith #(.WIDTH(WIDTH)) u_arith (
        .i_md_op       (md_op),
        .i_src_a       (src_a),
        .i_src_b       (src_b),
        .o_pending_hi  (w_arith_hi),
        .o_pending_lo  (w_arith_lo),
        .o_div_by_zero (w_arith_dz)
    );

    // Next-state logic: issue from IDLE, count down in RUN, retire or cancel.
    always_comb begin
        w_state_nx = r_state;
        w_cnt_nx   = r_cnt;
        w_hi_nx    = r_hi;
        w_lo_nx    = r_lo;
        w_capture  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                // flush in the same cycle drops the start.
                if (start && !flush) begin
                    case (w_op)
                        MD_MULT, MD_MULTU: begin
                            w_capture  = 1'b1;
                            w_cnt_nx   = CNT_W'(MULT_LAT);
                            w_state_nx = ST_RUN;
                        end
                        MD_DIV, MD_DIVU: begin
                            w_capture  = 1'b1;
                            w_cnt_nx   = CNT_W'(DIV_LAT);
                            w_state_nx = ST_RUN;
                        end
                        MD_MTHI: w_hi_nx = src_a;
                        MD_MTLO: w_lo_nx = src_a;
                        default: ;
                    endcase
                end
            end
            ST_RUN: begin
                // start is ignored here; the hazard unit never issues into RUN.
                if (flush) begin
                    w_state_nx = ST_IDLE;
                    w_cnt_nx   = '0;
                end else if (r_cnt <= CNT_W'(1)) begin
                    // Counter reaches zero on this edge: retire and drop busy together.
                    w_state_nx = ST_IDLE;
                    w_cnt_nx   = '0;
                    if (!r_pend_dz) begin
                        w_hi_nx = r_pend_hi;
                        w_lo_nx = r_pend_lo;
                    end
                end else begin
                    w_cnt_nx = r_cnt - CNT_W'(1);
                end
            end
            default: begin
                w_state_nx = ST_IDLE;
                w_cnt_nx   = '0;
            end
        endcase
    end

    // State, counter, HI/LO and pending-result registers; reset wins over all.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples pre-edge values regardless of statement order.
        if (reset) begin
            // NOTE: the pending registers are reset too, so a cancelled result
            // can never leak into HI/LO after reset.
            r_state   <= ST_IDLE;
            r_cnt     <= '0;
            r_hi      <= '0;
            r_lo      <= '0;
            r_pend_hi <= '0;
            r_pend_lo <= '0;
            r_pend_dz <= 1'b0;
        end else begin
            r_state <= w_state_nx;
            r_cnt   <= w_cnt_nx;
            r_hi    <= w_hi_nx;
            r_lo    <= w_lo_nx;
            if (w_capture) begin
                r_pend_hi <= w_arith_hi;
                r_pend_lo <= w_arith_lo;
                r_pend_dz <= w_arith_dz;
            end
        end
    end

    assign busy = (r_state == ST_RUN);
    assign hi   = r_hi;
    assign lo   = r_lo;

endmodule
